motor_drive_sequencer: RTL and testbench
========================================

MOTOR_DRIVE_SEQUENCER -- requirements
Module: motor_drive_sequencer

Interface
REQ-001 Parameter PWM_PERIOD, default 1000, gives the PWM period in clocks, with duty range 0..PWM_PERIOD.
REQ-002 Parameter RAMP_DIV, default 100, gives the clocks between duty ramp steps.
REQ-003 Parameter RAMP_STEP, default 1, gives the duty change per ramp step.
REQ-004 Parameter STALL_TIMEOUT, default 10_000_000, gives the clocks without a hall edge, in RUN, before a stall fault.
REQ-005 Parameter COAST_CYCLES, default 1000, gives the clocks all gates stay off before re-entering IDLE.
REQ-006 i_clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-007 i_reset  in  1  synchronous active-high reset.
REQ-008 i_enable  in  1  run request.
REQ-009 i_dir_ccw  in  1  requested direction.
REQ-010 i_target_duty  in  10  requested duty, in counts of PWM_PERIOD.
REQ-011 i_hall_state  in  3  raw hall sensor inputs.
REQ-012 i_fault_clear  in  1  fault acknowledge.
REQ-013 o_rot_ccw  out  1  direction applied to the commutation block.
REQ-014 o_pwm  out  1  PWM gate-enable for the commutation outputs.
REQ-015 o_duty  out  10  current ramped duty.
REQ-016 o_state  out  3  FSM state: IDLE=0, RUN=1, STOPPING=2, COAST=3, FAULT=4.
REQ-017 o_stall  out  1  stall/hall fault flag.
REQ-018 o_busy  out  1  high in any state other than IDLE.

Function
REQ-019 i_hall_state SHALL pass through a 2-flop synchronizer; all hall logic uses the synchronized value, giving 2 clocks of latency.
REQ-020 The PWM counter SHALL count 0..PWM_PERIOD-1 and wrap to 0, free-running in every state.
REQ-021 The applied duty SHALL be latched from o_duty only when the counter wraps to 0, so there are no mid-period glitches.
REQ-022 o_pwm SHALL be registered and equal (state==RUN or STOPPING) and (counter < applied duty).
- Duty 0 gives constant low.
- Duty PWM_PERIOD gives constant high.
REQ-023 The effective target SHALL be min(i_target_duty, PWM_PERIOD) in RUN and 0 in STOPPING.
REQ-024 Every RAMP_DIV clocks, o_duty SHALL move toward the effective target by RAMP_STEP, saturating exactly at the target.
- No overshoot.
- No underflow below 0.
REQ-025 IDLE: o_duty=0 and gates off.
- Transition to RUN when i_enable=1 and effective target>0.
- o_rot_ccw latches i_dir_ccw on that transition.
REQ-026 RUN: o_duty ramps toward the target.
- Transition to STOPPING when i_enable=0 or i_dir_ccw != o_rot_ccw.
REQ-027 STOPPING: o_duty ramps down; transition to COAST on the cycle o_duty==0.
REQ-028 COAST: gates off and a counter runs COAST_CYCLES clocks, then the FSM goes to IDLE.
- A still-asserted i_enable then restarts in the new direction.
REQ-029 RUN and STOPPING: a synchronized hall value of 3'b000 or 3'b111 SHALL cause an immediate transition to FAULT.
REQ-030 RUN: the stall counter SHALL clear on entry and on any synchronized hall change, saturate at STALL_TIMEOUT, and force FAULT on reaching it.
REQ-031 FAULT: o_duty=0, gates off, o_stall=1.
- Exit to IDLE only when i_fault_clear=1 and i_enable=0.
- i_fault_clear with i_enable=1 is ignored.
REQ-032 Transition priority SHALL be FAULT condition > stop/direction request > ramp.
- Simultaneous stall and i_enable drop goes to FAULT.
REQ-033 o_rot_ccw SHALL change only on the IDLE->RUN transition, never while gates can be on.
REQ-034 The duty, stall and coast counters SHALL be wide enough for their parameters, and none may wrap.

Reset
REQ-035 On i_reset=1 at a clock edge, the block SHALL set the following:
- state=IDLE
- o_duty=0, o_pwm=0, o_stall=0, o_busy=0, o_rot_ccw=0
- all counters and synchronizer flops to 0
REQ-036 Reset SHALL take effect mid-operation from any state, including FAULT, and override i_fault_clear.

Verification
REQ-037 With PWM_PERIOD=10, RAMP_DIV=2, RAMP_STEP=1, set enable=1 and target=5 with valid hall toggling: o_duty reaches 5 after 10 clocks and holds, and o_pwm is high 5 of every 10 clocks.
REQ-038 Set target=1023 (over range): o_duty saturates at 10 and o_pwm stays constantly high.
REQ-039 While in RUN with o_duty=5, flip i_dir_ccw: STOPPING ramps to 0, then COAST for COAST_CYCLES with o_pwm=0, then IDLE, then RUN with o_rot_ccw inverted.
REQ-040 With STALL_TIMEOUT=50, freeze the hall input in RUN: FAULT and o_stall=1 after 50 clocks (+2 sync). Then fault_clear with enable=1 stays in FAULT; fault_clear with enable=0 goes to IDLE.
REQ-041 Drive hall=3'b111 while in RUN: FAULT 3 clocks later and o_pwm=0 the next cycle.
REQ-042 Assert i_reset while in RUN at o_duty=7: the next cycle shows all outputs at their reset values.

Source files
------------

// File: rtl/motor_drive_sequencer_if.sv
// Control and status bundle between a motor supervisor and motor_drive_sequencer.
interface motor_drive_sequencer_if;
  logic       i_enable;
  logic       i_dir_ccw;
  logic [9:0] i_target_duty;
  logic [2:0] i_hall_state;
  logic       i_fault_clear;
  logic       o_rot_ccw;
  logic       o_pwm;
  logic [9:0] o_duty;
  logic [2:0] o_state;
  logic       o_stall;
  logic       o_busy;

  modport slave (
    input  i_enable, i_dir_ccw, i_target_duty, i_hall_state, i_fault_clear,
    output o_rot_ccw, o_pwm, o_duty, o_state, o_stall, o_busy
  );

  modport master (
    output i_enable, i_dir_ccw, i_target_duty, i_hall_state, i_fault_clear,
    input  o_rot_ccw, o_pwm, o_duty, o_state, o_stall, o_busy
  );
endinterface

// File: rtl/motor_drive_sequencer.sv
// BLDC drive sequencer: ramped PWM duty, direction changes via stop/coast, hall fault and stall detection.
// state    | meaning
// IDLE     | gates off, duty 0, waiting for enable with a non-zero target
// RUN      | duty ramps toward the capped target, stall timer active
// STOPPING | duty ramps down to 0 before coasting
// COAST    | gates off for COAST_CYCLES clocks
// FAULT    | gates off, stall flag set until cleared with enable low
module motor_drive_sequencer #(
  parameter int PWM_PERIOD    = 1000,
  parameter int RAMP_DIV      = 100,
  parameter int RAMP_STEP     = 1,
  parameter int STALL_TIMEOUT = 10_000_000,
  parameter int COAST_CYCLES  = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  motor_drive_sequencer_if.slave  bus
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV + 1) : 1;
  localparam int SW = $clog2(STALL_TIMEOUT + 1);
  localparam int CW = (COAST_CYCLES > 1) ? $clog2(COAST_CYCLES + 1) : 1;

  localparam logic [9:0]    PERIOD       = 10'(PWM_PERIOD);
  localparam logic [9:0]    STEP         = 10'(RAMP_STEP);
  localparam logic [RW-1:0] RAMP_RELOAD  = RW'(RAMP_DIV - 1);
  localparam logic [SW-1:0] STALL_TC     = SW'(STALL_TIMEOUT);
  localparam logic [CW-1:0] COAST_RELOAD = CW'(COAST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STOP  = 3'd2,
    S_COAST = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    hall_s1_q, hall_s2_q, hall_prev_q;
  logic [9:0]    cnt_q, cnt_d;
  logic [9:0]    applied_q, applied_d;
  logic [9:0]    duty_q, duty_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [CW-1:0] coast_q, coast_d;
  logic          rot_q, rot_d;
  logic          pwm_q, pwm_d;
  logic          busy_q, busy_d;
  logic          flt_q, flt_d;

  logic       hall_bad, hall_chg, wrap, active_q, active_d, ramp_tick;
  logic [9:0] tgt_cap, duty_tgt, duty_step;

  always_comb begin
    hall_bad  = (hall_s2_q == 3'b000) || (hall_s2_q == 3'b111);
    hall_chg  = (hall_s2_q != hall_prev_q);
    tgt_cap   = (bus.i_target_duty > PERIOD) ? PERIOD : bus.i_target_duty;

    wrap      = (cnt_q == PERIOD - 10'd1);
    cnt_d     = wrap ? 10'd0 : cnt_q + 10'd1;
    applied_d = wrap ? duty_q : applied_q;

    // Ramp timer restarts whenever the bridge is idle so the first step lands RAMP_DIV clocks after RUN entry.
    active_q  = (state_q == S_RUN) || (state_q == S_STOP);
    ramp_tick = active_q && (ramp_q == '0);
    ramp_d    = (!active_q || ramp_q == '0) ? RAMP_RELOAD : ramp_q - RW'(1);

    state_d = state_q;
    rot_d   = rot_q;
    coast_d = coast_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_enable && tgt_cap != 10'd0) begin
          state_d = S_RUN;
          rot_d   = bus.i_dir_ccw;
        end
      end
      S_RUN: begin
        if (hall_bad || stall_q == STALL_TC)                  state_d = S_FAULT;
        else if (!bus.i_enable || bus.i_dir_ccw != rot_q)     state_d = S_STOP;
      end
      S_STOP: begin
        if (hall_bad) state_d = S_FAULT;
        else if (duty_q == 10'd0) begin
          state_d = S_COAST;
          coast_d = COAST_RELOAD;
        end
      end
      S_COAST: begin
        if (coast_q == '0) state_d = S_IDLE;
        else               coast_d = coast_q - CW'(1);
      end
      S_FAULT: begin
        if (bus.i_fault_clear && !bus.i_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d == S_RUN) || (state_d == S_STOP);
    duty_tgt = (state_d == S_RUN) ? tgt_cap : 10'd0;
    if (duty_q < duty_tgt)
      duty_step = ((duty_tgt - duty_q) > STEP) ? duty_q + STEP : duty_tgt;
    else if (duty_q > duty_tgt)
      duty_step = ((duty_q - duty_tgt) > STEP) ? duty_q - STEP : duty_tgt;
    else
      duty_step = duty_q;
    duty_d = !active_d ? 10'd0 : (ramp_tick ? duty_step : duty_q);

    if (state_q == S_RUN && state_d == S_RUN)
      stall_d = hall_chg ? '0 : ((stall_q == STALL_TC) ? stall_q : stall_q + SW'(1));
    else
      stall_d = '0;

    pwm_d  = active_d && (cnt_d < applied_d);
    busy_d = (state_d != S_IDLE);
    flt_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      hall_s1_q   <= '0;
      hall_s2_q   <= '0;
      hall_prev_q <= '0;
      cnt_q       <= '0;
      applied_q   <= '0;
      duty_q      <= '0;
      ramp_q      <= '0;
      stall_q     <= '0;
      coast_q     <= '0;
      rot_q       <= 1'b0;
      pwm_q       <= 1'b0;
      busy_q      <= 1'b0;
      flt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hall_s1_q   <= bus.i_hall_state;
      hall_s2_q   <= hall_s1_q;
      hall_prev_q <= hall_s2_q;
      cnt_q       <= cnt_d;
      applied_q   <= applied_d;
      duty_q      <= duty_d;
      ramp_q      <= ramp_d;
      stall_q     <= stall_d;
      coast_q     <= coast_d;
      rot_q       <= rot_d;
      pwm_q       <= pwm_d;
      busy_q      <= busy_d;
      flt_q       <= flt_d;
    end
  end

  assign bus.o_state   = state_q;
  assign bus.o_duty    = duty_q;
  assign bus.o_pwm     = pwm_q;
  assign bus.o_rot_ccw = rot_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_stall   = flt_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed scenarios plus randomized traffic for motor_drive_sequencer, checked against a cycle reference model.
module tb_motor_drive_sequencer;
  localparam int P  = 10;
  localparam int RD = 2;
  localparam int RS = 1;
  localparam int ST = 50;
  localparam int CC = 20;
  localparam int IDLE = 0, RUN = 1, STOP = 2, COAST = 3, FAULT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  motor_drive_sequencer_if bus();

  motor_drive_sequencer #(
    .PWM_PERIOD(P), .RAMP_DIV(RD), .RAMP_STEP(RS),
    .STALL_TIMEOUT(ST), .COAST_CYCLES(CC)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int m_state, m_duty, m_rot, m_applied, m_pwm, m_cyc, m_act, m_still, m_coast;
  int h0, h1, h2;

  logic [2:0] hseq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  int  hidx = 0;
  int  hall_div = 0;
  bit  hall_auto = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour: rules applied once per clock edge on integer state.
  task automatic model_step();
    int nst, nrot, sync, prev, tcap, goal, nduty;
    bit bad, chg, tick, act_now, act_next;
    if (rst) begin
      m_state = IDLE; m_duty = 0; m_rot = 0; m_applied = 0; m_pwm = 0;
      m_cyc = 0; m_act = 0; m_still = 0; m_coast = 0;
      h0 = 0; h1 = 0; h2 = 0;
      return;
    end
    sync = h1; prev = h2;
    bad  = (sync == 0) || (sync == 7);
    chg  = (sync != prev);
    tcap = (int'(bus.i_target_duty) > P) ? P : int'(bus.i_target_duty);
    nst  = m_state; nrot = m_rot;
    case (m_state)
      IDLE:  if (bus.i_enable && tcap > 0) begin nst = RUN; nrot = bus.i_dir_ccw; end
      RUN:   if (bad || m_still == ST) nst = FAULT;
             else if (!bus.i_enable || bus.i_dir_ccw != m_rot) nst = STOP;
      STOP:  if (bad) nst = FAULT; else if (m_duty == 0) nst = COAST;
      COAST: begin m_coast--; if (m_coast == 0) nst = IDLE; end
      FAULT: if (bus.i_fault_clear && !bus.i_enable) nst = IDLE;
      default: nst = IDLE;
    endcase
    act_now = (m_state == RUN) || (m_state == STOP);
    tick = 0;
    if (act_now) begin m_act++; tick = (m_act % RD) == 0; end
    else m_act = 0;
    act_next = (nst == RUN) || (nst == STOP);
    goal  = (nst == RUN) ? tcap : 0;
    nduty = m_duty;
    if (!act_next) nduty = 0;
    else if (tick) begin
      if (m_duty < goal)      nduty = (m_duty + RS > goal) ? goal : m_duty + RS;
      else if (m_duty > goal) nduty = (m_duty - RS < goal) ? goal : m_duty - RS;
    end
    if (m_state == RUN && nst == RUN) m_still = chg ? 0 : ((m_still + 1 > ST) ? ST : m_still + 1);
    else m_still = 0;
    if (nst == COAST && m_state != COAST) m_coast = CC;
    if (m_cyc % P == P - 1) m_applied = m_duty;
    m_cyc++;
    m_state = nst; m_duty = nduty; m_rot = nrot;
    m_pwm = (act_next && ((m_cyc % P) < m_applied)) ? 1 : 0;
    h2 = h1; h1 = h0; h0 = int'(bus.i_hall_state);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("state", bus.o_state,   m_state);
    chk("duty",  bus.o_duty,    m_duty);
    chk("pwm",   bus.o_pwm,     m_pwm);
    chk("rot",   bus.o_rot_ccw, m_rot);
    chk("stall", bus.o_stall,   (m_state == FAULT) ? 1 : 0);
    chk("busy",  bus.o_busy,    (m_state != IDLE) ? 1 : 0);
    if (hall_auto) begin
      hall_div++;
      if (hall_div >= 3) begin
        hall_div = 0;
        hidx = (hidx + 1) % 6;
        bus.i_hall_state = hseq[hidx];
      end
    end
  endtask

  initial begin
    int n, k, acc, freeze;
    rst = 1'b1;
    bus.i_enable = 1'b0; bus.i_dir_ccw = 1'b0; bus.i_target_duty = 10'd0;
    bus.i_hall_state = hseq[0]; bus.i_fault_clear = 1'b0;
    cyc(); cyc();
    chk("reset_state", bus.o_state, 0);
    chk("reset_busy", bus.o_busy, 0);
    rst = 1'b0;
    hall_auto = 1;
    repeat (5) cyc();

    // Ramp to 5 and 50% PWM
    bus.i_enable = 1'b1; bus.i_target_duty = 10'd5;
    cyc();
    chk("enter_run", bus.o_state, RUN);
    repeat (10) cyc();
    chk("ramp_to_5", bus.o_duty, 5);
    repeat (10) cyc();
    acc = 0;
    for (int i = 0; i < 10; i++) begin cyc(); acc += int'(bus.o_pwm); end
    chk("pwm_half", acc, 5);

    // Over-range target caps at the period
    bus.i_target_duty = 10'd1023;
    repeat (20) cyc();
    chk("duty_cap", bus.o_duty, P);
    acc = 0;
    for (int i = 0; i < 10; i++) begin cyc(); acc += int'(bus.o_pwm); end
    chk("pwm_full", acc, 10);

    // Direction reversal through STOPPING and COAST
    bus.i_target_duty = 10'd5;
    repeat (12) cyc();
    chk("back_to_5", bus.o_duty, 5);
    bus.i_dir_ccw = 1'b1;
    cyc();
    chk("stopping", bus.o_state, STOP);
    for (int i = 0; i < 40 && bus.o_state != 3'(COAST); i++) cyc();
    chk("coast_reached", bus.o_state, COAST);
    n = 1; acc = int'(bus.o_pwm);
    for (int i = 0; i < 100 && bus.o_state == 3'(COAST); i++) begin
      cyc();
      if (bus.o_state == 3'(COAST)) begin n++; acc += int'(bus.o_pwm); end
    end
    chk("coast_len", n, CC);
    chk("coast_pwm", acc, 0);
    chk("idle_after_coast", bus.o_state, IDLE);
    cyc();
    chk("rerun", bus.o_state, RUN);
    chk("rerun_dir", bus.o_rot_ccw, 1);

    // Stall: freeze the hall input
    hall_auto = 0;
    k = 0;
    for (int i = 0; i < 80 && bus.o_state != 3'(FAULT); i++) begin cyc(); k++; end
    chk("stall_fault", bus.o_state, FAULT);
    chk("stall_latency", (k >= 48 && k <= 56) ? 1 : 0, 1);
    chk("stall_flag", bus.o_stall, 1);
    bus.i_fault_clear = 1'b1;
    repeat (3) cyc();
    chk("clear_ignored", bus.o_state, FAULT);
    bus.i_enable = 1'b0;
    cyc();
    chk("clear_idle", bus.o_state, IDLE);
    bus.i_fault_clear = 1'b0;
    hall_auto = 1;
    repeat (6) cyc();

    // Invalid hall code in RUN
    bus.i_enable = 1'b1;
    cyc();
    repeat (4) cyc();
    hall_auto = 0;
    bus.i_hall_state = 3'b111;
    cyc(); cyc();
    chk("hall_bad_wait", bus.o_state, RUN);
    cyc();
    chk("hall_bad_fault", bus.o_state, FAULT);
    cyc();
    chk("hall_bad_pwm", bus.o_pwm, 0);
    bus.i_enable = 1'b0; bus.i_fault_clear = 1'b1;
    bus.i_hall_state = hseq[hidx]; hall_auto = 1;
    cyc(); cyc();
    chk("hall_clear", bus.o_state, IDLE);
    bus.i_fault_clear = 1'b0;
    repeat (4) cyc();

    // Reset mid-run at duty 7
    bus.i_enable = 1'b1; bus.i_target_duty = 10'd9;
    for (int i = 0; i < 40 && bus.o_duty != 10'd7; i++) cyc();
    chk("duty_7", bus.o_duty, 7);
    rst = 1'b1;
    cyc();
    chk("rst_state", bus.o_state, 0);
    chk("rst_duty", bus.o_duty, 0);
    chk("rst_pwm", bus.o_pwm, 0);
    chk("rst_rot", bus.o_rot_ccw, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst = 1'b0;

    // Randomized traffic
    hall_auto = 0;
    freeze = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 39) == 0) bus.i_enable = ~bus.i_enable;
      if ($urandom_range(0, 79) == 0) bus.i_dir_ccw = ~bus.i_dir_ccw;
      if ($urandom_range(0, 59) == 0) bus.i_target_duty = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) bus.i_target_duty = 10'd1023;
      bus.i_fault_clear = ($urandom_range(0, 9) == 0);
      if (freeze > 0) freeze--;
      else if ($urandom_range(0, 299) == 0) freeze = 70;
      else if ($urandom_range(0, 249) == 0) bus.i_hall_state = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      else if ($urandom_range(0, 2) == 0) begin
        hidx = ($urandom_range(0, 3) == 0) ? (hidx + 5) % 6 : (hidx + 1) % 6;
        bus.i_hall_state = hseq[hidx];
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
